// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter.
// Provides the shift-mode encodings, which are visible on the unit's `mode` port,
// and the control FSM state encodings.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_SLL  = 2'b00,
        MODE_SRL  = 2'b01,
        MODE_SRA  = 2'b10,
        MODE_ROTR = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Single combinational shift stage. It shifts acc_i by amt_i (range 0..STEP) in the
// direction and fill selected by md_i.
//   acc_i  in   WIDTH    value to shift
//   amt_i  in   AMT_W    shift distance, 0..STEP
//   md_i   in   mode_t   SLL / SRL / SRA / ROTR
//   res_o  out  WIDTH    shifted value
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    localparam int unsigned AMT_W = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [AMT_W-1:0] amt_i,
    input  mode_t            md_i,
    output logic [WIDTH-1:0] res_o
);

    always_comb begin
        res_o = acc_i;
        unique case (md_i)
            MODE_SLL:  res_o = acc_i << amt_i;
            MODE_SRL:  res_o = acc_i >> amt_i;
            MODE_SRA:  res_o = $signed(acc_i) >>> amt_i;
            // Shifting the doubled word right leaves the rotated value in the low half.
            MODE_ROTR: res_o = WIDTH'({acc_i, acc_i} >> amt_i);
        endcase
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter for the MIPS datapath. Each cycle it shifts the operand by at
// most STEP bits, until the full shift amount has been applied. A start/ready/done
// handshake lets the control FSM stall on the unit.
//   clk      in   1        rising-edge clock
//   rst      in   1        synchronous active-high reset
//   start    in   1        request, taken only while ready=1
//   mode     in   2        00 SLL, 01 SRL, 10 SRA, 11 ROTR (sampled at accept)
//   data_in  in   WIDTH    operand (sampled at accept)
//   shamt    in   SHAMT_W  shift amount 0..WIDTH-1 (sampled at accept)
//   ready    out  1        idle, can accept
//   busy     out  1        operation in flight (SHIFT or DONE)
//   done     out  1        one-cycle pulse, result valid
//   result   out  WIDTH    registered shifted value
module iter_shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int unsigned AMT_W = $clog2(STEP + 1);
    // One extra bit, because STEP may equal WIDTH, which does not fit in SHAMT_W bits.
    localparam logic [SHAMT_W:0] STEP_L = (SHAMT_W + 1)'(STEP);

    state_t             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic [SHAMT_W-1:0] rem_q;
    logic [SHAMT_W-1:0] rem_d;
    mode_t              md_q;
    logic [WIDTH-1:0]   result_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;

    logic               last_step;
    logic [AMT_W-1:0]   step_amt;

    // s = min(rem, STEP). The step that consumes the remainder is the final one.
    always_comb begin
        last_step = ({1'b0, rem_q} <= STEP_L);
        step_amt  = last_step ? AMT_W'(rem_q) : AMT_W'(STEP);
        rem_d     = last_step ? '0 : rem_q - SHAMT_W'(STEP);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .acc_i (acc_q),
        .amt_i (step_amt),
        .md_i  (md_q),
        .res_o (acc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            rem_q    <= '0;
            md_q     <= MODE_SLL;
            result_q <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q   <= data_in;
                        rem_q   <= shamt;
                        md_q    <= mode_t'(mode);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (shamt == '0) begin
                            result_q <= data_in;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    if (last_step) begin
                        result_q <= acc_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
module tb_iter_shift_unit;

    localparam int unsigned NDUT = 3;
    localparam int unsigned STEPS [NDUT] = '{1, 4, 32};

    logic             clk = 1'b0;
    logic             rst;
    logic [NDUT-1:0]  start;
    logic [1:0]       mode;
    logic [31:0]      data_in;
    logic [4:0]       shamt;
    logic             ready_w  [NDUT];
    logic             busy_w   [NDUT];
    logic             done_w   [NDUT];
    logic [31:0]      result_w [NDUT];

    always #5 clk = ~clk;

    iter_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start[0]), .mode(mode), .data_in(data_in), .shamt(shamt),
        .ready(ready_w[0]), .busy(busy_w[0]), .done(done_w[0]), .result(result_w[0]));
    iter_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .start(start[1]), .mode(mode), .data_in(data_in), .shamt(shamt),
        .ready(ready_w[1]), .busy(busy_w[1]), .done(done_w[1]), .result(result_w[1]));
    iter_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(32)) u_s32 (
        .clk(clk), .rst(rst), .start(start[2]), .mode(mode), .data_in(data_in), .shamt(shamt),
        .ready(ready_w[2]), .busy(busy_w[2]), .done(done_w[2]), .result(result_w[2]));

    typedef struct {
        int unsigned dut;
        logic [1:0]  mode;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
        int unsigned inj;   // cycle offset of a stray start pulse, 0 = none
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int unsigned lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Single-shot reference shift.
    function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] x,
                                              input logic [4:0] s);
        case (m)
            2'b00:   return x << s;
            2'b01:   return x >> s;
            2'b10:   return $signed(x) >>> s;
            default: return (x >> s) | (x << (6'd32 - {1'b0, s}));
        endcase
    endfunction

    function automatic void add(input int unsigned d, input logic [1:0] m, input logic [31:0] x,
                                input logic [4:0] s, input logic [31:0] e, input int unsigned inj);
        vec_t v;
        v.dut = d; v.mode = m; v.data = x; v.shamt = s; v.exp = e; v.inj = inj;
        vecs.push_back(v);
    endfunction

    task automatic run_op(input vec_t v);
        exp_t        e;
        int unsigned lat;
        logic [31:0] r0;
        bit          changed;
        string       tag;
        int unsigned d;
        d   = v.dut;
        tag = $sformatf("step%0d_m%0d_x%h_sh%0d", STEPS[d], v.mode, v.data, v.shamt);
        e.res = v.exp;
        e.lat = (int'(v.shamt) + STEPS[d] - 1) / STEPS[d] + 1;
        sbq.push_back(e);
        @(negedge clk);
        mode = v.mode; data_in = v.data; shamt = v.shamt; start[d] = 1'b1;
        r0 = result_w[d];
        @(posedge clk); #1;
        start[d] = 1'b0;
        // Scramble inputs: the operation in flight must not see them.
        data_in = $urandom; mode = 2'($urandom); shamt = 5'($urandom);
        lat = 1; changed = 1'b0;
        if (v.shamt != 0) begin
            check({tag, "_busy_shift"}, 32'(busy_w[d]), 32'd1);
            check({tag, "_ready_shift"}, 32'(ready_w[d]), 32'd0);
        end
        while (done_w[d] !== 1'b1 && lat < 200) begin
            if (result_w[d] !== r0) changed = 1'b1;
            if (lat == v.inj) begin
                start[d] = 1'b1; data_in = 32'hFFFF_FFFF; shamt = 5'd1; mode = 2'b00;
            end
            @(posedge clk); #1;
            start[d] = 1'b0;
            lat++;
        end
        e = sbq.pop_front();
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        check({tag, "_result"}, result_w[d], e.res);
        check({tag, "_busy_done"}, 32'(busy_w[d]), 32'd1);
        check({tag, "_result_stable"}, 32'(changed), 32'd0);
        @(posedge clk); #1;
        check({tag, "_ready_after"}, 32'(ready_w[d]), 32'd1);
        check({tag, "_done_after"}, 32'(done_w[d]), 32'd0);
        check({tag, "_hold"}, result_w[d], e.res);
    endtask

    initial begin
        int unsigned lat;
        int unsigned pulses;
        logic [1:0]  rm;
        logic [31:0] rx;
        logic [4:0]  rs;

        add(0, 2'b00, 32'h0000_0001, 5'd2,  32'h0000_0004, 0);
        add(1, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 0);
        add(1, 2'b11, 32'h0000_00F1, 5'd4,  32'h1000_000F, 0);
        add(0, 2'b01, 32'h1234_5678, 5'd0,  32'h1234_5678, 0);
        add(0, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 5);
        add(1, 2'b10, 32'h7000_0000, 5'd5,  32'h0380_0000, 0);
        add(1, 2'b00, 32'h0000_00FF, 5'd8,  32'h0000_FF00, 0);
        add(2, 2'b11, 32'h1234_5678, 5'd31, 32'h2468_ACF0, 0);
        add(2, 2'b10, 32'h8000_0001, 5'd1,  32'hC000_0000, 0);
        add(0, 2'b10, 32'hF000_0000, 5'd3,  32'hFE00_0000, 0);
        add(0, 2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 0);
        add(1, 2'b01, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF, 0);
        for (int unsigned d = 0; d < NDUT; d++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                rm = 2'($urandom); rx = $urandom; rs = 5'($urandom);
                add(d, rm, rx, rs, ref_shift(rm, rx, rs), 0);
            end
        end

        rst = 1'b1; start = '0; mode = '0; data_in = '0; shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int unsigned d = 0; d < NDUT; d++) begin
            check($sformatf("reset_ready_%0d", d), 32'(ready_w[d]), 32'd1);
            check($sformatf("reset_busy_%0d", d), 32'(busy_w[d]), 32'd0);
            check($sformatf("reset_done_%0d", d), 32'(done_w[d]), 32'd0);
            check($sformatf("reset_result_%0d", d), result_w[d], 32'd0);
        end
        @(negedge clk); rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst = 1'b1; start[0] = 1'b1; data_in = 32'h0000_ABCD; shamt = 5'd3; mode = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0; start[0] = 1'b0;
        check("rst_prio_ready", 32'(ready_w[0]), 32'd1);
        check("rst_prio_busy", 32'(busy_w[0]), 32'd0);
        @(posedge clk); #1;
        check("rst_prio_no_done", 32'(done_w[0]), 32'd0);
        check("rst_prio_idle", 32'(busy_w[0]), 32'd0);

        // Abort a long operation mid-shift with reset.
        run_op('{0, 2'b00, 32'h0000_0001, 5'd2, 32'h0000_0004, 0});
        @(negedge clk);
        mode = 2'b01; data_in = 32'h8000_0000; shamt = 5'd31; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready", 32'(ready_w[0]), 32'd1);
        check("abort_busy", 32'(busy_w[0]), 32'd0);
        check("abort_result", result_w[0], 32'd0);
        pulses = 0;
        for (int unsigned c = 0; c < 40; c++) begin
            if (done_w[0] === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        check("abort_still_idle", 32'(ready_w[0]), 32'd1);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
